// File: rtl/stacker_pkg.sv
// stacker_pkg: geometry, colours and game-state encoding for the Stacker pixel renderer
package stacker_pkg;
  localparam int HBP  = 144;
  localparam int HFP  = 784;
  localparam int VBP  = 35;
  localparam int VFP  = 515;
  localparam int X0   = 180;
  localparam int CELL = 40;
  localparam int COLS = 7;
  localparam int ROWS = 12;
  localparam logic [7:0] COL_OFF  = 8'h00;
  localparam logic [7:0] COL_GRID = 8'h49;
  localparam logic [7:0] COL_MOVE = 8'hE0;
  localparam logic [7:0] COL_SET  = 8'h1C;
  localparam logic [7:0] COL_WIN  = 8'hFC;
  typedef enum logic [1:0] {
    GS_PLAY = 2'd0,
    GS_WIN  = 2'd1,
    GS_LOSE = 2'd2,
    GS_RSVD = 2'd3
  } game_state_t;
  typedef struct packed {
    logic       active;
    logic       in_board;
    logic [2:0] col;
    logic [3:0] srow;
    logic       grid_x;
    logic       grid_y;
  } loc_t;
endpackage

// File: rtl/stacker_cell_locator.sv
// stacker_cell_locator: stage 1, maps raw hc/vc onto board column/row and grid-line flags
module stacker_cell_locator
  import stacker_pkg::*;
(
  input  logic       dclk,
  input  logic       clr,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output loc_t       loc
);
  loc_t nxt;
  int x, y;
  // constant-compare decode: cell index is the count of cell boundaries already passed
  always_comb begin
    x = int'(hc) - HBP;
    y = int'(vc) - VBP;
    nxt = '0;
    nxt.active = int'(hc) >= HBP && int'(hc) < HFP && int'(vc) >= VBP && int'(vc) < VFP;
    nxt.in_board = x >= X0 && x < X0 + COLS * CELL;
    for (int k = 1; k < COLS; k++) if (x >= X0 + k * CELL) nxt.col = 3'(k);
    for (int k = 1; k < ROWS; k++) if (y >= k * CELL) nxt.srow = 4'(k);
    for (int k = 0; k < COLS; k++) if (x == X0 + k * CELL) nxt.grid_x = 1'b1;
    for (int k = 0; k < ROWS; k++) if (y == k * CELL) nxt.grid_y = 1'b1;
  end
  // stage 1 register
  always_ff @(posedge dclk or posedge clr)
    if (clr) loc <= '0;
    else loc <= nxt;
endmodule

// File: rtl/stacker_pixel_renderer.sv
// stacker_pixel_renderer: Stacker board pixel colour stage with per-frame board latch and sync delay
module stacker_pixel_renderer
  import stacker_pkg::*;
(
  input  logic       dclk,
  input  logic       clr,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       board_wr_en,
  input  logic [3:0] board_wr_row,
  input  logic [6:0] board_wr_data,
  input  logic [3:0] moving_row,
  input  logic [6:0] moving_mask,
  input  logic [1:0] game_state,
  output logic [7:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out
);
  logic [COLS-1:0] shadow [ROWS];
  logic [COLS-1:0] disp [ROWS];
  logic [3:0] mrow;
  logic [COLS-1:0] mmask;
  game_state_t gs;
  logic [4:0] frame_cnt;
  logic hs_d, vs_d, frame_start, set_bit, mov_bit, play;
  logic [3:0] brow;
  logic [7:0] set_col, rgb_nxt;
  loc_t loc;
  assign frame_start = hc == 10'd0 && vc == 10'd0;
  stacker_cell_locator u_loc (
    .dclk(dclk),
    .clr(clr),
    .hc(hc),
    .vc(vc),
    .loc(loc)
  );
  // shadow board written by game logic; out-of-range rows dropped
  always_ff @(posedge dclk or posedge clr)
    if (clr) shadow <= '{default: '0};
    else if (board_wr_en && board_wr_row < 4'(ROWS)) shadow[board_wr_row] <= board_wr_data;
  // frame latch: nonblocking copy takes the pre-write shadow on a same-cycle write
  always_ff @(posedge dclk or posedge clr)
    if (clr) begin
      disp <= '{default: '0};
      mrow <= 4'd15;
      mmask <= '0;
      gs <= GS_PLAY;
      frame_cnt <= '0;
    end else if (frame_start) begin
      disp <= shadow;
      mrow <= moving_row;
      mmask <= moving_mask;
      gs <= game_state_t'(game_state);
      frame_cnt <= frame_cnt + 5'd1;
    end
  // stage 2 lookup and colour priority; a moving row >= 12 never matches brow
  always_comb begin
    brow = 4'(ROWS - 1) - loc.srow;
    set_bit = disp[brow][loc.col];
    play = gs != GS_WIN && gs != GS_LOSE;
    mov_bit = play && mrow == brow && mmask[loc.col];
    set_col = gs == GS_WIN ? (frame_cnt[4] ? COL_WIN : COL_SET) :
              gs == GS_LOSE ? (frame_cnt[4] ? COL_OFF : COL_MOVE) : COL_SET;
    rgb_nxt = !(loc.active && loc.in_board) ? COL_OFF :
              (loc.grid_x || loc.grid_y) ? COL_GRID :
              mov_bit ? COL_MOVE : set_bit ? set_col : COL_OFF;
  end
  // stage 2 register and matching two-stage sync delay
  always_ff @(posedge dclk or posedge clr)
    if (clr) begin
      rgb <= '0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb <= rgb_nxt;
      hs_d <= hsync_in;
      vs_d <= vsync_in;
      hsync_out <= hs_d;
      vsync_out <= vs_d;
    end
endmodule

// File: tb/tb_stacker_pixel_renderer.sv
// tb_stacker_pixel_renderer: random and directed checks against a behavioural Stacker renderer model
module tb_stacker_pixel_renderer;
  logic dclk = 1'b0, clr = 1'b1;
  logic [9:0] hc = '0, vc = '0;
  logic hsync_in = 1'b1, vsync_in = 1'b1, board_wr_en = 1'b0;
  logic [3:0] board_wr_row = '0, moving_row = 4'd15;
  logic [6:0] board_wr_data = '0, moving_mask = '0;
  logic [1:0] game_state = '0;
  logic [7:0] rgb;
  logic hsync_out, vsync_out;
  int tests = 0, fails = 0;
  bit [6:0] m_shadow [12];
  bit [6:0] m_disp [12];
  bit [6:0] m_mmask;
  int m_mrow, m_gs, m_fc;
  logic [7:0] exp_rgb;
  logic exp_hs, exp_vs;
  always #5 dclk = ~dclk;
  stacker_pixel_renderer dut (
    .dclk(dclk),
    .clr(clr),
    .hc(hc),
    .vc(vc),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .board_wr_en(board_wr_en),
    .board_wr_row(board_wr_row),
    .board_wr_data(board_wr_data),
    .moving_row(moving_row),
    .moving_mask(moving_mask),
    .game_state(game_state),
    .rgb(rgb),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );
  task automatic check(string tag, logic [7:0] got, logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_shadow[i] = '0;
      m_disp[i] = '0;
    end
    m_mrow = 15;
    m_mmask = '0;
    m_gs = 0;
    m_fc = 0;
    exp_rgb = 8'h00;
    exp_hs = 1'b1;
    exp_vs = 1'b1;
  endtask
  function automatic logic [7:0] ref_rgb(int h, int v);
    int x, y, col, r;
    if (h < 144 || h >= 784 || v < 35 || v >= 515) return 8'h00;
    x = h - 144 - 180;
    y = v - 35;
    if (x < 0 || x >= 7 * 40) return 8'h00;
    if (x % 40 == 0 || y % 40 == 0) return 8'h49;
    col = x / 40;
    r = 11 - y / 40;
    if (m_gs != 1 && m_gs != 2 && m_mrow == r && m_mmask[col]) return 8'hE0;
    if (!m_disp[r][col]) return 8'h00;
    if (m_gs == 1) return m_fc[4] ? 8'hFC : 8'h1C;
    if (m_gs == 2) return m_fc[4] ? 8'h00 : 8'hE0;
    return 8'h1C;
  endfunction
  task automatic cyc();
    logic [7:0] e;
    logic hs, vs;
    @(posedge dclk);
    if (hc == 10'd0 && vc == 10'd0) begin
      m_disp = m_shadow;
      m_mrow = int'(moving_row);
      m_mmask = moving_mask;
      m_gs = int'(game_state);
      m_fc = (m_fc + 1) % 32;
    end
    if (board_wr_en && int'(board_wr_row) < 12) m_shadow[board_wr_row] = board_wr_data;
    e = ref_rgb(int'(hc), int'(vc));
    hs = hsync_in;
    vs = vsync_in;
    #1;
    check("rgb", rgb, exp_rgb);
    check("hsync", 8'(hsync_out), 8'(exp_hs));
    check("vsync", 8'(vsync_out), 8'(exp_vs));
    exp_rgb = e;
    exp_hs = hs;
    exp_vs = vs;
  endtask
  task automatic probe(string tag, int h, int v, logic [7:0] want);
    hc = 10'(h);
    vc = 10'(v);
    cyc();
    hc = 10'd1;
    vc = 10'd0;
    cyc();
    check(tag, rgb, want);
  endtask
  task automatic latch();
    hc = 10'd0;
    vc = 10'd0;
    cyc();
    hc = 10'd1;
  endtask
  task automatic write_row(int row, int data);
    board_wr_en = 1'b1;
    board_wr_row = 4'(row);
    board_wr_data = 7'(data);
    hc = 10'd1;
    vc = 10'd0;
    cyc();
    board_wr_en = 1'b0;
  endtask
  task automatic rand_cycles(int n);
    repeat (n) begin
      board_wr_en = $urandom_range(7) == 0;
      board_wr_row = 4'($urandom_range(15));
      board_wr_data = 7'($urandom);
      moving_row = 4'($urandom_range(15));
      moving_mask = 7'($urandom);
      game_state = 2'($urandom);
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      if ($urandom_range(40) == 0) begin
        hc = 10'd0;
        vc = 10'd0;
      end else if ($urandom_range(1) == 0) begin
        hc = 10'($urandom_range(799));
        vc = 10'($urandom_range(524));
      end else begin
        hc = 10'($urandom_range(610, 318));
        vc = 10'($urandom_range(520, 30));
      end
      cyc();
    end
  endtask
  initial begin
    model_reset();
    #12;
    check("reset_rgb", rgb, 8'h00);
    check("reset_hsync", 8'(hsync_out), 8'h01);
    check("reset_vsync", 8'(vsync_out), 8'h01);
    @(posedge dclk);
    #1;
    clr = 1'b0;
    probe("empty_cell", 344, 495, 8'h00);
    probe("empty_grid", 324, 495, 8'h49);
    write_row(0, 7'b0000001);
    latch();
    probe("set_cell", 344, 495, 8'h1C);
    probe("set_cell2", 325, 476, 8'h1C);
    probe("set_grid", 324, 495, 8'h49);
    moving_row = 4'd0;
    moving_mask = 7'h01;
    latch();
    probe("move_over_set", 344, 495, 8'hE0);
    game_state = 2'd1;
    repeat (32) begin
      latch();
      probe("win_blink", 344, 495, m_fc[4] ? 8'hFC : 8'h1C);
    end
    game_state = 2'd2;
    repeat (32) begin
      latch();
      probe("lose_blink", 344, 495, m_fc[4] ? 8'h00 : 8'hE0);
    end
    game_state = 2'd0;
    moving_row = 4'd15;
    moving_mask = 7'h00;
    latch();
    board_wr_en = 1'b1;
    board_wr_row = 4'd5;
    board_wr_data = 7'h7F;
    hc = 10'd0;
    vc = 10'd0;
    cyc();
    board_wr_en = 1'b0;
    probe("collide_old", 464, 295, 8'h00);
    latch();
    probe("collide_new", 464, 295, 8'h1C);
    write_row(12, 7'h7F);
    latch();
    for (int r = 0; r < 12; r++) probe("row12_ignored", 424, 35 + (11 - r) * 40 + 20, r == 5 ? 8'h1C : 8'h00);
    moving_row = 4'd13;
    moving_mask = 7'h7F;
    latch();
    for (int r = 0; r < 12; r++) probe("move_row13", 504, 35 + (11 - r) * 40 + 20, r == 5 ? 8'h1C : 8'h00);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    probe("pre_reset", 344, 495, 8'h1C);
    #2;
    clr = 1'b1;
    #1;
    check("midreset_rgb", rgb, 8'h00);
    check("midreset_hsync", 8'(hsync_out), 8'h01);
    check("midreset_vsync", 8'(vsync_out), 8'h01);
    @(posedge dclk);
    #1;
    clr = 1'b0;
    model_reset();
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    moving_row = 4'd15;
    moving_mask = 7'h00;
    probe("post_reset_cell", 344, 495, 8'h00);
    probe("post_reset_grid", 324, 495, 8'h49);
    write_row(3, 7'h55);
    moving_row = 4'd7;
    moving_mask = 7'h2A;
    foreach (m_disp[i]) if (i < 0) $display("unused");
    for (int l = 0; l < 9; l++) begin
      int lines [9] = '{0, 1, 2, 34, 35, 100, 314, 514, 524};
      for (int h = 0; h < 800; h++) begin
        hc = 10'(h);
        vc = 10'(lines[l]);
        hsync_in = h >= 96;
        vsync_in = lines[l] >= 2;
        cyc();
      end
    end
    rand_cycles(20000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
